rv32i_memarbiter: RTL

- Arbitrates one single-port memory bus between two requesters: the data port (load/store requests from the memory-access stage) and the instruction-fetch port.
- Allows one outstanding transaction at a time. Registers all memory-side outputs and returns read data, a one-cycle ack, and a timeout error to the granted requester.
- Sits between the core's fetch and memory-access stages and the shared memory / bus bridge.

---
 rtl/rv32i_memarbiter.sv | 184 ++++++++++++++++++
 1 files changed

// File: rtl/rv32i_memarbiter.sv
// Two-port (data / instruction-fetch) arbiter onto one single-port memory bus.
// One transaction in flight; IDLE -> BUSY -> DONE, with per-transaction timeout.
module rv32i_memarbiter #(
    parameter int TIMEOUT        = 255,
    parameter bit FIXED_PRIORITY = 1'b0
) (
    input  logic        clk,
    input  logic        rst_n,
    // data port
    input  logic        d_req,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    input  logic [3:0]  d_wmask,
    input  logic        d_we,
    output logic        d_ack,
    output logic        d_err,
    output logic [31:0] d_rdata,
    // fetch port
    input  logic        i_req,
    input  logic [31:0] i_addr,
    output logic        i_ack,
    output logic        i_err,
    output logic [31:0] i_rdata,
    // memory bus
    output logic        m_req,
    output logic [31:0] m_addr,
    output logic [31:0] m_wdata,
    output logic [3:0]  m_wmask,
    output logic        m_we,
    input  logic        m_ack,
    input  logic [31:0] m_rdata,
    // status
    output logic        busy,
    output logic [1:0]  dbg_state
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int            CW       = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam bit            TO_EN    = (TIMEOUT != 0);
    localparam logic [CW-1:0] CNT_LAST = (TIMEOUT > 0) ? CW'(TIMEOUT - 1) : '0;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          pref_fetch_q, pref_fetch_d;
    logic          gnt_fetch_q, gnt_fetch_d;
    logic          m_req_q, m_req_d;
    logic [31:0]   m_addr_q, m_addr_d;
    logic [31:0]   m_wdata_q, m_wdata_d;
    logic [3:0]    m_wmask_q, m_wmask_d;
    logic          m_we_q, m_we_d;
    logic          d_ack_q, d_ack_d, d_err_q, d_err_d;
    logic          i_ack_q, i_ack_d, i_err_q, i_err_d;
    logic [31:0]   d_rdata_q, d_rdata_d, i_rdata_q, i_rdata_d;
    logic          pick_fetch;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            pref_fetch_q <= 1'b0;
            gnt_fetch_q  <= 1'b0;
            m_req_q      <= 1'b0;
            m_addr_q     <= '0;
            m_wdata_q    <= '0;
            m_wmask_q    <= '0;
            m_we_q       <= 1'b0;
            d_ack_q      <= 1'b0;
            d_err_q      <= 1'b0;
            i_ack_q      <= 1'b0;
            i_err_q      <= 1'b0;
            d_rdata_q    <= '0;
            i_rdata_q    <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            pref_fetch_q <= pref_fetch_d;
            gnt_fetch_q  <= gnt_fetch_d;
            m_req_q      <= m_req_d;
            m_addr_q     <= m_addr_d;
            m_wdata_q    <= m_wdata_d;
            m_wmask_q    <= m_wmask_d;
            m_we_q       <= m_we_d;
            d_ack_q      <= d_ack_d;
            d_err_q      <= d_err_d;
            i_ack_q      <= i_ack_d;
            i_err_q      <= i_err_d;
            d_rdata_q    <= d_rdata_d;
            i_rdata_q    <= i_rdata_d;
        end
    end

    // Fetch wins only if it is alone or it holds the round-robin preference.
    assign pick_fetch = i_req && (!d_req || pref_fetch_q);

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        pref_fetch_d = pref_fetch_q;
        gnt_fetch_d  = gnt_fetch_q;
        m_req_d      = m_req_q;
        m_addr_d     = m_addr_q;
        m_wdata_d    = m_wdata_q;
        m_wmask_d    = m_wmask_q;
        m_we_d       = m_we_q;
        d_ack_d      = 1'b0;
        d_err_d      = 1'b0;
        i_ack_d      = 1'b0;
        i_err_d      = 1'b0;
        d_rdata_d    = d_rdata_q;
        i_rdata_d    = i_rdata_q;

        case (state_q)
            IDLE: begin
                if (d_req || i_req) begin
                    gnt_fetch_d  = pick_fetch;
                    pref_fetch_d = FIXED_PRIORITY ? 1'b0 : !pick_fetch;
                    m_req_d      = 1'b1;
                    cnt_d        = '0;
                    state_d      = BUSY;
                    if (pick_fetch) begin
                        m_addr_d  = i_addr;
                        m_wdata_d = '0;
                        m_wmask_d = '0;
                        m_we_d    = 1'b0;
                    end else begin
                        m_addr_d  = d_addr;
                        m_wdata_d = d_wdata;
                        m_wmask_d = d_we ? d_wmask : 4'b0000;
                        m_we_d    = d_we;
                    end
                end
            end
            BUSY: begin
                if (m_ack) begin
                    m_req_d = 1'b0;
                    state_d = DONE;
                    if (gnt_fetch_q) begin
                        i_ack_d   = 1'b1;
                        i_rdata_d = m_rdata;
                    end else begin
                        d_ack_d   = 1'b1;
                        d_rdata_d = m_rdata;
                    end
                end else if (TO_EN && (cnt_q == CNT_LAST)) begin
                    m_req_d = 1'b0;
                    state_d = DONE;
                    if (gnt_fetch_q) begin
                        i_err_d = 1'b1;
                    end else begin
                        d_err_d = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign d_ack     = d_ack_q;
    assign d_err     = d_err_q;
    assign d_rdata   = d_rdata_q;
    assign i_ack     = i_ack_q;
    assign i_err     = i_err_q;
    assign i_rdata   = i_rdata_q;
    assign m_req     = m_req_q;
    assign m_addr    = m_addr_q;
    assign m_wdata   = m_wdata_q;
    assign m_wmask   = m_wmask_q;
    assign m_we      = m_we_q;
    assign busy      = (state_q != IDLE);
    assign dbg_state = state_q;

endmodule
